// File: rtl/aes_top_if.sv
// Byte-serial load/unload bus of the AES-128 core.
// The host drives the request strobes and the input byte; the core returns
// the low byte of its data register.
interface aes_top_if;
  logic       staenc;
  logic       stadec;
  logic       load_shift;
  logic       loadkey;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output staenc, stadec, load_shift, loadkey, din, input dout);
  modport slave  (input staenc, stadec, load_shift, loadkey, din, output dout);
endinterface

// File: rtl/aes_top.sv
// AES-128 iterative encrypt/decrypt core, one round per clock.
// Key and data are byte shift registers; AES byte 0 lives in bits [127:120].
// Round keys are produced on the fly: forward schedule for encryption and
// key expansion, inverse schedule (starting from the stored round key 10)
// for decryption. S-boxes are built from GF(2^8) inversion plus affine map.
module aes_top (
  input  logic     clk,
  input  logic     rst,
  aes_top_if.slave bus
);

  typedef enum logic [1:0] {IDLE, KEYEXP, ENC, DEC} state_t;

  state_t       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [127:0] key_q, key_d;
  logic [127:0] lastKey_q, lastKey_d;
  logic [127:0] roundKey_q, roundKey_d;
  logic [3:0]   round_q, round_d;
  logic         keyDirty_q, keyDirty_d;

  logic [31:0]  ksWord, ksRot, ksSub, ksT;
  logic [31:0]  fw0, fw1, fw2, fw3;
  logic [3:0]   rconIdx;
  logic [127:0] fwdKey, invKey;
  logic [127:0] encOut, decOut;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128, which also maps 0 to 0
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      acc = gfMul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gfInv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gfInv(b);
  endfunction

  function automatic logic [7:0] rconOf(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] m;
    logic [7:0]   a0, a1, a2, a3;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      m[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return m;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] m;
    logic [7:0]   a0, a1, a2, a3;
    m = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      m[127-32*c -: 32] = {
        gfMul(a0, 8'h0e) ^ gfMul(a1, 8'h0b) ^ gfMul(a2, 8'h0d) ^ gfMul(a3, 8'h09),
        gfMul(a0, 8'h09) ^ gfMul(a1, 8'h0e) ^ gfMul(a2, 8'h0b) ^ gfMul(a3, 8'h0d),
        gfMul(a0, 8'h0d) ^ gfMul(a1, 8'h09) ^ gfMul(a2, 8'h0e) ^ gfMul(a3, 8'h0b),
        gfMul(a0, 8'h0b) ^ gfMul(a1, 8'h0d) ^ gfMul(a2, 8'h09) ^ gfMul(a3, 8'h0e)};
    end
    return m;
  endfunction

  // SubBytes + ShiftRows + (MixColumns unless last) + AddRoundKey
  function automatic logic [127:0] encRound(input logic [127:0] s, input logic [127:0] rk,
                                            input logic last);
    logic [127:0] sr;
    sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return (last ? sr : mixColumns(sr)) ^ rk;
  endfunction

  // InvShiftRows + InvSubBytes + AddRoundKey + (InvMixColumns unless last)
  function automatic logic [127:0] decRound(input logic [127:0] s, input logic [127:0] rk,
                                            input logic last);
    logic [127:0] ark;
    ark = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ark[127-8*(r+4*c) -: 8] = invSbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    ark = ark ^ rk;
    return last ? ark : invMixColumns(ark);
  endfunction

  // Shared key-schedule step (4 S-boxes) and both round datapaths
  always_comb begin
    ksWord  = (state_q == DEC) ? (roundKey_q[63:32] ^ roundKey_q[31:0]) : roundKey_q[31:0];
    ksRot   = {ksWord[23:0], ksWord[31:24]};
    ksSub   = '0;
    for (int i = 0; i < 4; i++) ksSub[8*i +: 8] = sbox(ksRot[8*i +: 8]);
    rconIdx = (state_q == DEC) ? (4'd10 - round_q) : (round_q + 4'd1);
    ksT     = ksSub ^ {rconOf(rconIdx), 24'h000000};
    fw0     = roundKey_q[127:96] ^ ksT;
    fw1     = roundKey_q[95:64] ^ fw0;
    fw2     = roundKey_q[63:32] ^ fw1;
    fw3     = roundKey_q[31:0] ^ fw2;
    fwdKey  = {fw0, fw1, fw2, fw3};
    invKey  = {roundKey_q[127:96] ^ ksT,
               roundKey_q[95:64] ^ roundKey_q[127:96],
               roundKey_q[63:32] ^ roundKey_q[95:64],
               roundKey_q[31:0] ^ roundKey_q[63:32]};
    encOut  = encRound(data_q, roundKey_q, round_q == 4'd10);
    decOut  = decRound(data_q, roundKey_q, round_q == 4'd10);
  end

  // Next-state logic: request arbitration in IDLE, round sequencing otherwise
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    key_d      = key_q;
    lastKey_d  = lastKey_q;
    roundKey_d = roundKey_q;
    round_d    = round_q;
    keyDirty_d = keyDirty_q;
    unique case (state_q)
      IDLE: begin
        if (bus.staenc) begin
          state_d    = ENC;
          roundKey_d = key_q;
          round_d    = 4'd0;
        end else if (bus.stadec) begin
          state_d    = DEC;
          roundKey_d = lastKey_q;
          round_d    = 4'd0;
        end else if (bus.loadkey) begin
          key_d      = {bus.din, key_q[127:8]};
          keyDirty_d = 1'b1;
        end else begin
          if (keyDirty_q) begin
            keyDirty_d = 1'b0;
            state_d    = KEYEXP;
            roundKey_d = key_q;
            round_d    = 4'd0;
          end
          if (bus.load_shift) data_d = {bus.din, data_q[127:8]};
        end
      end
      KEYEXP: begin
        if (bus.loadkey) begin
          key_d      = {bus.din, key_q[127:8]};
          keyDirty_d = 1'b1;
          state_d    = IDLE;
          round_d    = 4'd0;
        end else begin
          roundKey_d = fwdKey;
          round_d    = round_q + 4'd1;
          if (round_q == 4'd9) begin
            lastKey_d = fwdKey;
            state_d   = IDLE;
            round_d   = 4'd0;
          end
        end
        if (bus.load_shift) data_d = {bus.din, data_q[127:8]};
      end
      ENC: begin
        data_d     = (round_q == 4'd0) ? (data_q ^ roundKey_q) : encOut;
        roundKey_d = fwdKey;
        round_d    = round_q + 4'd1;
        if (round_q == 4'd10) begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      end
      DEC: begin
        data_d     = (round_q == 4'd0) ? (data_q ^ roundKey_q) : decOut;
        roundKey_d = invKey;
        round_d    = round_q + 4'd1;
        if (round_q == 4'd10) begin
          state_d = IDLE;
          round_d = 4'd0;
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      key_q      <= '0;
      lastKey_q  <= '0;
      roundKey_q <= '0;
      round_q    <= 4'd0;
      keyDirty_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      key_q      <= key_d;
      lastKey_q  <= lastKey_d;
      roundKey_q <= roundKey_d;
      round_q    <= round_d;
      keyDirty_q <= keyDirty_d;
    end
  end

  assign bus.dout = data_q[7:0];

endmodule

// File: tb/tb_aes_top.sv
// Directed bench for aes_top using FIPS-197 vectors.
module tb_aes_top;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   failCount  = 0;

  aes_top_if bus();

  aes_top dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] KEY2    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %02h, expected %02h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then settle 1 time unit past the edge
  task automatic applyStimulus(input logic enc, input logic dec, input logic shift,
                               input logic key, input logic [7:0] data);
    bus.staenc     = enc;
    bus.stadec     = dec;
    bus.load_shift = shift;
    bus.loadkey    = key;
    bus.din        = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Last AES byte (bits [7:0]) goes first
  task automatic sendKey(input logic [127:0] k);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, k[8*i +: 8]);
  endtask

  task automatic sendData(input logic [127:0] d);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, d[8*i +: 8]);
  endtask

  // dout shows AES byte 15 first, byte 0 last
  task automatic unloadCheck(input string tag, input logic [127:0] expected);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i), bus.dout, expected[8*i +: 8]);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    end
  endtask

  initial begin
    bus.staenc     = 1'b0;
    bus.stadec     = 1'b0;
    bus.load_shift = 1'b0;
    bus.loadkey    = 1'b0;
    bus.din        = 8'h00;
    rst = 1'b1;
    #17;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("resetDout", bus.dout, 8'h00);

    $display("[TB] Scenario 1: asynchronous reset mid-encryption");
    sendKey(KEY2);
    sendData(PT2);
    checkOutput("loadedDout", bus.dout, PT2[7:0]);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idleCycles(3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncResetDout", bus.dout, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idleCycles(13);
    unloadCheck("zeroEnc", ZERO_CT);

    $display("[TB] Scenario 2: key load and encryption");
    sendKey(KEY2);
    sendData(PT2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idleCycles(11);
    checkOutput("encLatency", bus.dout, CT2[7:0]);
    idleCycles(2);
    unloadCheck("enc2", CT2);

    $display("[TB] Scenario 3: decryption");
    sendData(CT2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idleCycles(13);
    unloadCheck("dec2", PT2);

    $display("[TB] Scenario 5: requests ignored while busy");
    sendData(PT2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'haa);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h55);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hc3);
    idleCycles(9);
    unloadCheck("busyEnc", CT2);

    $display("[TB] Scenario 6: back-to-back encrypt then decrypt");
    sendData(PT2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idleCycles(11);
    checkOutput("b2bCipher", bus.dout, CT2[7:0]);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idleCycles(13);
    unloadCheck("b2bPlain", PT2);

    $display("[TB] Scenario 4: FIPS-197 C.1 vector");
    sendKey(KEY_C1);
    sendData(PT_C1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    idleCycles(13);
    unloadCheck("c1Enc", CT_C1);
    sendData(CT_C1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idleCycles(13);
    unloadCheck("c1Dec", PT_C1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/aes_top.md
Name: aes_top

Overview:
- AES-128 encrypt/decrypt core with a byte-serial load/unload interface.
- The 128-bit cipher key and the 128-bit data block are each shifted in one byte per clock.
- One encryption or decryption runs iteratively at one round per clock; the result is shifted out a byte per clock through the same data shift register.
- Sits between a narrow 8-bit bus and any host that needs single-block AES (FIPS-197).

Parameters:
None (AES-128 fixed: Nk=4, Nr=10).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
staenc  input  1  single-cycle pulse: start encryption of the data register
stadec  input  1  single-cycle pulse: start decryption of the data register
load_shift  input  1  shift data register right one byte per cycle, din entering at top
loadkey  input  1  shift key register right one byte per cycle, din entering at top
din  input  8  serial byte input for key and data
dout  output  8  data register bits [7:0], combinational from the register

Behaviour:
Byte ordering
- Both 128-bit registers are byte shift registers: on shift, reg <= {din, reg[127:8]}.
- After 16 shifts, the first byte sent sits in [7:0] and the last byte in [127:120].
- AES byte 0 (FIPS state s0,0 / key byte 0) is bits [127:120]. Hosts therefore send the last AES byte first.
- Unload: with load_shift high, dout presents the bytes from [7:0] upward, i.e. AES byte 15 first and byte 0 last. din is shifted in meanwhile and is don't-care.

Reset
- Data register = 0, key register = 0, last-round-key register = 0, round counter = 0, FSM = IDLE, dout = 0.
- Reset mid-operation aborts immediately to this state.

FSM states: IDLE, KEYEXP, ENC, DEC.
- IDLE:
  - loadkey high: shift key; cleared flag key_dirty set.
  - loadkey low while key_dirty: clear key_dirty, go to KEYEXP.
  - load_shift high: shift data.
  - staenc: go to ENC.
  - stadec: go to DEC.
- KEYEXP: 10 cycles of forward key expansion from the cipher key. Round key 10 is stored in the last-round-key register, then return to IDLE. Data shifting (load_shift) remains allowed in KEYEXP.
- ENC:
  - Start cycle: state ^= rk0.
  - Then rounds 1..10 each take one cycle: SubBytes, ShiftRows, MixColumns (omitted in round 10), AddRoundKey.
  - Round keys are generated on the fly. Return to IDLE after round 10.
- DEC:
  - Start cycle: state ^= rk10 (from the last-round-key register).
  - Then 10 cycles of InvShiftRows, InvSubBytes, AddRoundKey(rk9..rk0), InvMixColumns (omitted in the final round).
  - Round keys are derived by the inverse key schedule. Return to IDLE.
- Latency: the result is in the data register and on dout 11 cycles after the cycle in which the start pulse is sampled. It remains stable until shifted or reset.

Priority and boundary rules
- In IDLE, priority is staenc > stadec > loadkey > load_shift. Lower-priority requests in the same cycle are dropped.
- While in ENC or DEC, staenc, stadec, loadkey and load_shift are ignored; the registers are not disturbed.
- loadkey while in KEYEXP aborts the expansion, shifts the key and sets key_dirty.
- stadec issued before key expansion completes uses a stale rk10; host contract is to wait 10 cycles after the last key byte.
- Fewer than 16 shifts leave partially shifted contents; no byte counting is done.
- S-box and inverse S-box: 16 parallel instances each for data plus 4 for the key schedule. Either lookup tables or composite-field inversion is acceptable; results must be bit-exact with FIPS-197.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> dout = 00 immediately, FSM IDLE; a subsequent staenc operates on an all-zero state.
2. Key + encrypt: loadkey bytes 3c,4f,cf,09,88,15,f7,ab,a6,d2,ae,28,16,15,7e,2b. Then load_shift bytes 34,07,37,e0,a2,98,31,31,8d,30,5a,88,a8,f6,43,32. Then staenc for 1 cycle, wait 13 cycles, then load_shift for 16 cycles -> dout sequence 32,0b,6a,19,97,85,11,dc,fb,09,dc,02,1d,84,25,39.
3. Decrypt: load_shift bytes 32,0b,6a,19,97,85,11,dc,fb,09,dc,02,1d,84,25,39, then stadec, wait 13 cycles, then unload -> dout sequence 34,07,37,e0,a2,98,31,31,8d,30,5a,88,a8,f6,43,32.
4. FIPS-197 C.1 vector: key 000102…0f, plaintext 00112233…ff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a (bytes shifted out in reverse order); decryption round-trips back to the plaintext.
5. Busy protection: pulse loadkey, load_shift and staenc during ENC -> result and key unchanged; the same ciphertext as in scenario 2 is produced.
6. Back-to-back: issue stadec on the cycle immediately after ENC completes, without unloading -> the data register returns to the original plaintext.
